// File: rtl/ddc_mixer_cic.sv
// rtl/ddc_mixer_cic.sv - quadrature mixer followed by per-channel CIC decimators
// I/Q share one decimation counter and strobe; integrators wrap modulo 2^ACC_W by design.
module ddc_mixer_cic #(
  parameter int DATA_W = 10,
  parameter int LO_W   = 10,
  parameter int DEC    = 16,
  parameter int STAGES = 3,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_in,
  input  logic [LO_W-1:0]   lo_cos,
  input  logic [LO_W-1:0]   lo_sin,
  input  logic              in_valid,
  output logic [OUT_W-1:0]  i_out,
  output logic [OUT_W-1:0]  q_out,
  output logic              out_valid
);

  localparam int PROD_W = DATA_W + LO_W;
  localparam int CNT_W  = $clog2(DEC);
  localparam int ACC_W  = PROD_W + STAGES * CNT_W;
  localparam int SHIFT  = ACC_W - OUT_W;

  logic signed [PROD_W-1:0] adc_x, cos_x, sin_x;
  logic signed [PROD_W-1:0] p_i, p_q;
  logic                     m_valid;
  logic                     dec_stb;
  logic [CNT_W-1:0]         cnt;

  logic signed [ACC_W-1:0]  int_i [STAGES];
  logic signed [ACC_W-1:0]  int_q [STAGES];
  logic signed [ACC_W-1:0]  dly_i [STAGES];
  logic signed [ACC_W-1:0]  dly_q [STAGES];
  logic signed [ACC_W-1:0]  comb_in_i [STAGES];
  logic signed [ACC_W-1:0]  comb_in_q [STAGES];
  logic signed [ACC_W-1:0]  comb_out_i, comb_out_q;

  // Operands widened first so the product is the exact full-precision value.
  assign adc_x = PROD_W'($signed(adc_in));
  assign cos_x = PROD_W'($signed(lo_cos));
  assign sin_x = PROD_W'($signed(lo_sin));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_i     <= '0;
      p_q     <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        p_i <= adc_x * cos_x;
        p_q <= adc_x * sin_x;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        int_i[k] <= '0;
        int_q[k] <= '0;
      end
      cnt     <= '0;
      dec_stb <= 1'b0;
    end else begin
      dec_stb <= m_valid && (cnt == CNT_W'(DEC - 1));
      if (m_valid) begin
        int_i[0] <= int_i[0] + ACC_W'(p_i);
        int_q[0] <= int_q[0] + ACC_W'(p_q);
        for (int k = 1; k < STAGES; k++) begin
          int_i[k] <= int_i[k] + int_i[k-1];
          int_q[k] <= int_q[k] + int_q[k-1];
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Each comb stage input is what its delay register captures on the strobe.
  always_comb begin
    comb_out_i = int_i[STAGES-1];
    comb_out_q = int_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_in_i[k] = comb_out_i;
      comb_in_q[k] = comb_out_q;
      comb_out_i   = comb_out_i - dly_i[k];
      comb_out_q   = comb_out_q - dly_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dec_stb;
      if (dec_stb) begin
        for (int k = 0; k < STAGES; k++) begin
          dly_i[k] <= comb_in_i[k];
          dly_q[k] <= comb_in_q[k];
        end
        i_out <= OUT_W'(comb_out_i >>> SHIFT);
        q_out <= OUT_W'(comb_out_q >>> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_ddc_mixer_cic.sv
// tb/tb_ddc_mixer_cic.sv - randomized and directed bench for ddc_mixer_cic against an impulse-response model
module tb_ddc_mixer_cic;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  adc_in = '0;
  logic [9:0]  lo_cos = '0;
  logic [9:0]  lo_sin = '0;
  logic        in_valid = 1'b0;
  logic [15:0] i_out, q_out;
  logic        out_valid;

  ddc_mixer_cic dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_in    (adc_in),
    .lo_cos    (lo_cos),
    .lo_sin    (lo_sin),
    .in_valid  (in_valid),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic signed [15:0] i;
    logic signed [15:0] q;
  } exp_t;

  int     cyc = 0, nacc = 0, nchk = 0, npass = 0, nstrobe = 0;
  int     last_strobe_cyc = -1, e16 = 0;
  longint xi [0:32767];
  longint xq [0:32767];
  longint a_w, c_w, s_w;
  exp_t   expq [$];
  exp_t   enew, ecur;
  bit     lit_en = 1'b0;
  int     lit_period = 16;
  logic signed [15:0] lit_i = '0, lit_q = '0;

  task automatic check(input string nm, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Cascaded-integrator response to one sample, n edges later, is the triangular number (n-1)n/2.
  function automatic longint tri_n(input longint n);
    return (n >= 1) ? (n - 1) * n / 2 : 64'sd0;
  endfunction

  function automatic longint wt(input longint n);
    return tri_n(n) - 3 * tri_n(n - D) + 3 * tri_n(n - 2 * D) - tri_n(n - 3 * D);
  endfunction

  function automatic logic signed [15:0] cic_out(input bit use_q, input int k);
    longint s = 0;
    int lo = k * D - 3 * D - 1;
    if (lo < 1) lo = 1;
    for (int i = lo; i <= k * D - 2; i++)
      s += (use_q ? xq[i] : xi[i]) * wt(longint'(k * D - i));
    s = s >>> 16;
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && nacc < 32767) begin
      nacc++;
      a_w = longint'($signed(adc_in));
      c_w = longint'($signed(lo_cos));
      s_w = longint'($signed(lo_sin));
      xi[nacc] = a_w * c_w;
      xq[nacc] = a_w * s_w;
      if (nacc % D == 0) begin
        enew.cyc = cyc + 2;
        enew.i   = cic_out(1'b0, nacc / D);
        enew.q   = cic_out(1'b1, nacc / D);
        expq.push_back(enew);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_i_out", $signed(i_out), 0);
      check("rst_q_out", $signed(q_out), 0);
    end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
      ecur = expq.pop_front();
      nstrobe++;
      check("out_valid_strobe", out_valid, 1);
      check("i_out", $signed(i_out), ecur.i);
      check("q_out", $signed(q_out), ecur.q);
      if (lit_en && nstrobe >= 4) begin
        check("lit_i_out", $signed(i_out), lit_i);
        check("lit_q_out", $signed(q_out), lit_q);
      end
      if (lit_en && nstrobe >= 2) check("strobe_period", cyc - last_strobe_cyc, lit_period);
      last_strobe_cyc = cyc;
    end else begin
      check("out_valid_idle", out_valid, 0);
    end
  end

  task automatic reset_dut(input int n);
    rst_n = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    nacc = 0;
    nstrobe = 0;
    last_strobe_cyc = -1;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random data and gaps
  task automatic drive(input int n, input logic [9:0] a, input logic [9:0] c,
                       input logic [9:0] s, input int mode);
    for (int j = 0; j < n; j++) begin
      if (mode == 2) begin
        adc_in   = 10'($urandom);
        lo_cos   = 10'($urandom);
        lo_sin   = 10'($urandom);
        in_valid = ($urandom_range(0, 9) < 7);
      end else begin
        adc_in   = a;
        lo_cos   = c;
        lo_sin   = s;
        in_valid = (mode == 0) || (j % 2 == 0);
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #1;
    reset_dut(3);

    lit_en = 1'b1; lit_period = 16; lit_i = 16'sd1600; lit_q = 16'sd0;
    drive(128, 10'd100, 10'd256, 10'd0, 0);
    idle(4);
    check("dc_i_strobes", nstrobe, 8);

    reset_dut(2);
    lit_i = 16'sd0; lit_q = -16'sd1600;
    drive(128, 10'h39C, 10'd0, 10'd256, 0);
    idle(4);
    check("dc_negq_strobes", nstrobe, 8);

    reset_dut(2);
    lit_i = 16'sd16384; lit_q = 16'sd0;
    drive(20000, 10'h200, 10'h200, 10'd0, 0);
    idle(4);
    check("wrap_strobes", nstrobe, 1250);

    reset_dut(2);
    lit_period = 32; lit_i = 16'sd1600; lit_q = 16'sd0;
    drive(256, 10'd100, 10'd256, 10'd0, 1);
    idle(4);
    check("gapped_strobes", nstrobe, 8);
    lit_en = 1'b0;

    reset_dut(2);
    drive(7, 10'd100, 10'd256, 10'd0, 0);
    reset_dut(3);
    drive(16, 10'd100, 10'd256, 10'd0, 0);
    e16 = cyc;
    idle(4);
    check("midreset_latency", last_strobe_cyc - e16, 2);
    check("midreset_strobes", nstrobe, 1);

    reset_dut(2);
    drive(16, 10'd100, 10'd256, 10'd0, 0);
    e16 = cyc;
    idle(4);
    check("latency", last_strobe_cyc - e16, 2);
    check("latency_first_i", $signed(i_out), 218);

    reset_dut(2);
    drive(3000, '0, '0, '0, 2);
    reset_dut(2);
    drive(2000, '0, '0, '0, 2);
    idle(5);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
